// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - uart_tx_state_t : transmitter frame state
//   - uart_parity_t   : encoding of the io_parity configuration input
//   - UART_STOP_ONE / UART_STOP_TWO : encoding of io_stopBits
//   - parity_enabled(): true only for the even and odd encodings; the
//     unused encoding 3 behaves like "no parity"
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } uart_parity_t;

  localparam logic UART_STOP_ONE = 1'b0;
  localparam logic UART_STOP_TWO = 1'b1;

  function automatic logic parity_enabled(input logic [1:0] parity);
    return (parity == EVEN) || (parity == ODD);
  endfunction

endpackage

// File: rtl/uart_tx_tick_gen.sv
// uart_tx_tick_gen
//   Loadable baud down-counter. tick is high while the count is zero; on
//   that cycle (or whenever load is high) the counter reloads, so a reload
//   value of D yields one tick every D+1 cycles.
//   Ports:
//     clk     in   rising-edge clock
//     reset   in   asynchronous, active-low
//     load    in   restart the bit period from reload
//     reload  in   DIV_WIDTH  value loaded on load or tick
//     tick    out  end of the current bit period
module uart_tx_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] reload,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q;

  assign tick = (count_q == '0);

  // The counter free-runs even when the transmitter is idle; the frame
  // logic only looks at tick outside IDLE and every frame starts with load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load || tick) begin
      count_q <= reload;
    end else begin
      count_q <= count_q - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream
//   Stream-fed asynchronous serial transmitter. Each accepted byte goes out
//   as start bit, DATA_WIDTH data bits LSB first, optional parity bit and one
//   or two stop bits. Divider, parity and stop configuration are captured
//   together with the byte, so changing them mid-frame affects only later
//   frames.
//   Ports:
//     clk              in   rising-edge clock
//     reset            in   asynchronous, active-low
//     io_input_valid   in   upstream byte available
//     io_input_ready   out  byte taken this cycle when valid && ready
//     io_input_payload in   DATA_WIDTH byte to send
//     io_clockDivider  in   DIV_WIDTH  bit period = value + 1 clocks
//     io_parity        in   2  0 none, 1 even, 2 odd, 3 none
//     io_stopBits      in   0 one stop bit, 1 two stop bits
//     io_txd           out  registered serial line, idle high
//     io_busy          out  high while a frame is on the line
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_input_valid,
  output logic                  io_input_ready,
  input  logic [DATA_WIDTH-1:0] io_input_payload,
  input  logic [DIV_WIDTH-1:0]  io_clockDivider,
  input  logic [1:0]            io_parity,
  input  logic                  io_stopBits,
  output logic                  io_txd,
  output logic                  io_busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  uart_tx_state_t        state_q, state_d;
  logic                  txd_q, txd_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  parity_en_q;
  logic                  parity_bit_q;
  logic                  two_stop_q;
  logic                  tick;
  logic                  accept;
  logic                  last_data;
  logic                  last_stop;
  logic [DIV_WIDTH-1:0]  reload_value;

  assign accept    = io_input_valid && io_input_ready;
  assign last_data = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt_q == {{(CNT_W-1){1'b0}}, two_stop_q});
  assign io_txd    = txd_q;

  // On accept the new divider is not latched yet, so it is fed straight
  // through; afterwards every reload uses the frame's captured divider.
  assign reload_value = accept ? io_clockDivider : div_q;

  uart_tx_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .reload(reload_value),
    .tick  (tick)
  );

  // State register; busy is registered from the next state so it lines up
  // exactly with the state it reflects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      io_busy <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      io_busy <= (state_d != IDLE);
      txd_q   <= txd_d;
    end
  end

  // Next-state logic. The final stop bit can hand straight over to a new
  // start bit when a byte is accepted on that same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (tick) state_d = DATA;
      DATA:   if (tick && last_data) state_d = parity_en_q ? PARITY : STOP;
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick && last_stop) state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. txd_d is the level for the bit that begins at the coming edge,
  // which keeps the line registered without adding a cycle of latency.
  // Data bit k+1 is shift_q[1] because the shift happens on the same edge.
  always_comb begin
    io_input_ready = (state_q == IDLE) || (state_q == STOP && tick && last_stop);
    txd_d          = txd_q;
    case (state_q)
      IDLE:   if (accept) txd_d = 1'b0;
      START:  if (tick) txd_d = shift_q[0];
      DATA: begin
        if (tick) begin
          if (last_data) txd_d = parity_en_q ? parity_bit_q : 1'b1;
          else           txd_d = shift_q[1];
        end
      end
      PARITY: if (tick) txd_d = 1'b1;
      STOP: begin
        if (tick) txd_d = (last_stop && accept) ? 1'b0 : 1'b1;
      end
      default: txd_d = 1'b1;
    endcase
  end

  // Frame datapath: captures the byte and its configuration on accept, then
  // walks the bit counter through data bits and stop bits on each tick.
  // The parity bit is resolved once at capture time from the whole byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      div_q        <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      two_stop_q   <= UART_STOP_ONE;
    end else if (accept) begin
      bit_cnt_q    <= '0;
      shift_q      <= io_input_payload;
      div_q        <= io_clockDivider;
      parity_en_q  <= parity_enabled(io_parity);
      parity_bit_q <= (^io_input_payload) ^ (io_parity == ODD);
      two_stop_q   <= io_stopBits;
    end else if (tick) begin
      case (state_q)
        START:  bit_cnt_q <= '0;
        DATA: begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= last_data ? '0 : bit_cnt_q + CNT_W'(1);
        end
        PARITY: bit_cnt_q <= '0;
        STOP:   bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        default: bit_cnt_q <= bit_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream
//   Self-checking bench for uart_tx_stream. Accepted bytes are pushed with
//   their captured configuration into a scoreboard queue; a line monitor
//   checks every cycle of every frame against that entry and decodes the byte.
module tb_uart_tx_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        io_input_valid = 1'b0;
  logic        io_input_ready;
  logic [7:0]  io_input_payload = 8'h00;
  logic [15:0] io_clockDivider = 16'd0;
  logic [1:0]  io_parity = 2'd0;
  logic        io_stopBits = 1'b0;
  logic        io_txd;
  logic        io_busy;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         parEn;
    bit         parBit;
    int         stops;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         par;
    int         stop;
    bit         parBit;
    int         expLen;
  } vec_t;

  frame_t sbQ[$];
  int assertCount = 0;
  int failCount = 0;
  int cycleCount = 0;
  int busyCycles = 0;
  int readyBusyCycles = 0;
  int lastStart = 0;
  int prevStart = 0;
  bit inFrame = 1'b0;

  uart_tx_stream #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_input_valid  (io_input_valid),
    .io_input_ready  (io_input_ready),
    .io_input_payload(io_input_payload),
    .io_clockDivider (io_clockDivider),
    .io_parity       (io_parity),
    .io_stopBits     (io_stopBits),
    .io_txd          (io_txd),
    .io_busy         (io_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  always @(negedge clk) begin
    if (io_busy === 1'b1) busyCycles++;
    if (io_busy === 1'b1 && io_input_ready === 1'b1) readyBusyCycles++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit expParity(input logic [7:0] d, input int par);
    return (^d) ^ (par == 2);
  endfunction

  // Offer a byte and wait for the handshake; the scoreboard entry is pushed
  // in the cycle the DUT takes it. Valid is left high for back-to-back use.
  task automatic applyStimulus(input logic [7:0] data, input int d, input int par,
                               input int stop, input bit parBit);
    frame_t e;
    bit got;
    got = 1'b0;
    @(negedge clk);
    io_input_payload = data;
    io_clockDivider  = d[15:0];
    io_parity        = par[1:0];
    io_stopBits      = stop[0];
    io_input_valid   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (io_input_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("accept_%02h", data), got, 1);
    if (got) begin
      e.data   = data;
      e.div    = d;
      e.parEn  = (par == 1) || (par == 2);
      e.parBit = parBit;
      e.stops  = stop ? 2 : 1;
      sbQ.push_back(e);
      @(posedge clk);
    end else begin
      io_input_valid = 1'b0;
    end
  endtask

  task automatic dropValid();
    @(negedge clk);
    io_input_valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    bit done;
    done = 1'b0;
    for (int n = 0; n < maxCycles; n++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && !inFrame) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_timeout", done, 1);
    if (!done) sbQ.delete();
  endtask

  // Line monitor: every cycle of each frame is compared with the expected
  // level; a reset during the frame abandons the entry.
  initial begin : monitor
    frame_t e;
    int nbits;
    bit aborted;
    bit bitOk;
    bit expBit;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && io_txd === 1'b0) begin
        if (sbQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_start: got start bit, expected idle line");
        end else begin
          e = sbQ[0];
          inFrame = 1'b1;
          prevStart = lastStart;
          lastStart = cycleCount;
          nbits = 1 + 8 + (e.parEn ? 1 : 0) + e.stops;
          aborted = 1'b0;
          rx = 8'h00;
          for (int b = 0; b < nbits; b++) begin
            bitOk = 1'b1;
            if (b == 0)                      expBit = 1'b0;
            else if (b <= 8)                 expBit = e.data[b-1];
            else if (e.parEn && b == 9)      expBit = e.parBit;
            else                             expBit = 1'b1;
            for (int c = 0; c <= e.div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (reset !== 1'b1) begin
                aborted = 1'b1;
                break;
              end
              if (io_txd !== expBit) bitOk = 1'b0;
              if (b >= 1 && b <= 8 && c == e.div / 2) rx[b-1] = io_txd;
            end
            if (aborted) break;
            checkOutput($sformatf("frame_%02h_bit%0d", e.data, b), bitOk, 1);
          end
          void'(sbQ.pop_front());
          if (!aborted) checkOutput($sformatf("frame_%02h_byte", e.data), rx, e.data);
          inFrame = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin : main
    vec_t vecs[7];
    int b0;
    int r0;
    logic [7:0] fifoQ[$];
    int pushed;
    int maxOcc;
    bit acc;
    frame_t e;

    vecs[0] = '{8'h55, 3, 0, 0, 1'b0, 40};
    vecs[1] = '{8'h07, 0, 1, 0, 1'b1, 11};
    vecs[2] = '{8'h07, 0, 2, 0, 1'b0, 11};
    vecs[3] = '{8'hA5, 1, 0, 1, 1'b0, 22};
    vecs[4] = '{8'h3C, 2, 2, 1, 1'b1, 36};
    vecs[5] = '{8'hFF, 0, 3, 0, 1'b0, 10};
    vecs[6] = '{8'h80, 4, 1, 0, 1'b1, 55};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_txd", io_txd, 1);
    checkOutput("reset_busy", io_busy, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", io_input_ready, 1);
    checkOutput("post_reset_txd", io_txd, 1);
    checkOutput("post_reset_busy", io_busy, 0);

    // Single frames across dividers, parity modes and stop-bit counts
    for (int i = 0; i < 7; i++) begin
      b0 = busyCycles;
      applyStimulus(vecs[i].data, vecs[i].div, vecs[i].par, vecs[i].stop, vecs[i].parBit);
      dropValid();
      waitDrain(300);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_busy_len", i), busyCycles - b0, vecs[i].expLen);
      checkOutput($sformatf("vec%0d_idle_busy", i), io_busy, 0);
      checkOutput($sformatf("vec%0d_idle_txd", i), io_txd, 1);
    end

    // Back-to-back frames with valid held high
    b0 = busyCycles;
    r0 = readyBusyCycles;
    applyStimulus(8'hA5, 1, 0, 1, 1'b0);
    applyStimulus(8'h3C, 1, 0, 1, 1'b0);
    dropValid();
    waitDrain(300);
    @(negedge clk);
    checkOutput("b2b_busy_len", busyCycles - b0, 44);
    checkOutput("b2b_ready_pulses", readyBusyCycles - r0, 2);
    checkOutput("b2b_start_spacing", lastStart - prevStart, 22);

    // Configuration changed mid-frame applies only to the next frame
    applyStimulus(8'h5A, 3, 0, 0, 1'b0);
    dropValid();
    repeat (6) @(negedge clk);
    io_clockDivider = 16'd7;
    io_parity = 2'd1;
    applyStimulus(8'hC3, 7, 1, 0, expParity(8'hC3, 1));
    dropValid();
    waitDrain(400);

    // Reset asserted during data bit 3
    applyStimulus(8'h96, 3, 0, 0, 1'b0);
    dropValid();
    repeat (17) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_txd", io_txd, 1);
    checkOutput("midreset_busy", io_busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_txd", io_txd, 1);
    checkOutput("after_reset_busy", io_busy, 0);
    checkOutput("after_reset_ready", io_input_ready, 1);
    checkOutput("after_reset_sb_empty", sbQ.size(), 0);
    applyStimulus(8'hFF, 3, 0, 0, 1'b0);
    dropValid();
    waitDrain(300);

    // Upstream FIFO feeding the transmitter: 16 bytes pushed one per cycle
    io_clockDivider = 16'd2;
    io_parity = 2'd0;
    io_stopBits = 1'b0;
    pushed = 0;
    maxOcc = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (pushed == 16 && fifoQ.size() == 0) break;
      @(negedge clk);
      io_input_valid = (fifoQ.size() > 0);
      io_input_payload = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
      acc = io_input_valid && (io_input_ready === 1'b1);
      if (acc) begin
        e.data = fifoQ[0];
        e.div = 2;
        e.parEn = 1'b0;
        e.parBit = 1'b0;
        e.stops = 1;
        sbQ.push_back(e);
      end
      @(posedge clk);
      if (acc) void'(fifoQ.pop_front());
      if (pushed < 16) begin
        fifoQ.push_back(pushed[7:0]);
        pushed++;
      end
      if (fifoQ.size() > maxOcc) maxOcc = fifoQ.size();
    end
    @(negedge clk);
    io_input_valid = 1'b0;
    waitDrain(300);
    checkOutput("fifo_filled", maxOcc >= 14, 1);
    checkOutput("fifo_occupancy_end", fifoQ.size(), 0);
    checkOutput("fifo_all_pushed", pushed, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
